avm_uart_arbiter: RTL and testbench

- Shares the single Avalon-MM master port to the RS-232 UART (RX/TX/STATUS registers) between two internal requesters. Typical pairing: requester 0 is the RSA receive/decrypt sequencer, requester 1 is a debug/status poller.
- Arbitration is round-robin with an optional per-requester lock for atomic sequences such as status poll followed by an RX read.
- A waitrequest timeout aborts hung transfers, so one stalled slave cannot deadlock both requesters.

---
 rtl/avm_uart_pkg.sv | 24 ++
 rtl/avm_wait_timer.sv | 34 +++
 rtl/avm_uart_arbiter.sv | 160 ++++++++++++++++
 tb/tb_avm_uart_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avm_uart_pkg.sv
// Shared definitions for the Avalon-MM UART access path.
// Also used by the RSA wrapper, so the UART register map lives here.
//   state_t        : arbiter FSM state encoding
//   *_BASE         : UART register byte addresses
//   *_OK_BIT       : STATUS register ready flags
//   onehot2()      : requester index -> one-hot grant vector
package avm_uart_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam int RX_BASE     = 0;
    localparam int TX_BASE     = 4;
    localparam int STATUS_BASE = 8;
    localparam int TX_OK_BIT   = 6;
    localparam int RX_OK_BIT   = 7;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/avm_wait_timer.sv
// Saturating counter of waitrequest cycles for the transfer in flight.
// Ports:
//   avm_clk  : clock
//   avm_rst  : synchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : count this cycle
//   expired  : count has reached TIMEOUT-1; never asserted when TIMEOUT == 0
module avm_wait_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic avm_clk,
    input  logic avm_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    always_ff @(posedge avm_clk) begin
        if (avm_rst || clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (count == CNT_LAST);

endmodule

// File: rtl/avm_uart_arbiter.sv
// Two-requester round-robin arbiter in front of the UART Avalon-MM master.
// A requester can hold the port across transfers with req_lock, and a
// waitrequest timeout aborts a hung transfer so the other side can proceed.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | no transfer on the bus; arbitrate and issue next cycle
//  S_BUSY | transfer owned by 'owner' is on the bus, waiting to finish
//
// Ports:
//   avm_clk, avm_rst      : clock, synchronous active-high reset
//   req_valid/write/lock  : per-requester request, direction, lock-next
//   req_addr, req_wdata   : per-requester payload, packed by requester index
//   req_done, req_err     : one-cycle completion / timeout pulses
//   rsp_rdata             : read data, meaningful while req_done is high
//   grant                 : one-hot owner of the bus, 0 when idle
//   avm_*                 : Avalon-MM master port
module avm_uart_arbiter
    import avm_uart_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [1:0]          req_lock,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_done,
    output logic [1:0]          req_err,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          grant,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic                avm_waitrequest
);

    state_t state, state_nxt;

    logic owner;
    logic last_grant;
    logic lock_valid;
    logic lock_idx;

    logic pick_valid;
    logic pick;

    logic xfer_done;
    logic xfer_err;
    logic timer_expired;
    logic timer_clr;
    logic timer_en;

    // A synchronous reset in the same cycle suppresses any pulse.
    assign xfer_done = (state == S_BUSY) && !avm_waitrequest && !avm_rst;
    assign xfer_err  = (state == S_BUSY) && avm_waitrequest && timer_expired && !avm_rst;

    assign timer_en  = (state == S_BUSY) && avm_waitrequest;
    assign timer_clr = (state != S_BUSY) || xfer_done || xfer_err;

    avm_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state         <= S_IDLE;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            lock_valid    <= 1'b0;
            lock_idx      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    // A lock whose owner went away is released here.
                    if (lock_valid && !req_valid[lock_idx]) begin
                        lock_valid <= 1'b0;
                    end
                    if (pick_valid) begin
                        owner         <= pick;
                        avm_address   <= pick ? req_addr[2*ADDR_W-1:ADDR_W]
                                              : req_addr[ADDR_W-1:0];
                        avm_writedata <= pick ? req_wdata[2*DATA_W-1:DATA_W]
                                              : req_wdata[DATA_W-1:0];
                        avm_read      <= ~req_write[pick];
                        avm_write     <= req_write[pick];
                    end
                end
                S_BUSY: begin
                    if (xfer_done || xfer_err) begin
                        avm_read   <= 1'b0;
                        avm_write  <= 1'b0;
                        last_grant <= owner;
                        lock_idx   <= owner;
                    end
                    if (xfer_done) begin
                        lock_valid <= req_lock[owner];
                    end else if (xfer_err) begin
                        lock_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick       = 1'b0;
        state_nxt  = state;

        if (lock_valid && req_valid[lock_idx]) begin
            pick_valid = 1'b1;
            pick       = lock_idx;
        end else if (&req_valid) begin
            pick_valid = 1'b1;
            pick       = ~last_grant;
        end else if (req_valid[0]) begin
            pick_valid = 1'b1;
            pick       = 1'b0;
        end else if (req_valid[1]) begin
            pick_valid = 1'b1;
            pick       = 1'b1;
        end

        case (state)
            S_IDLE: if (pick_valid) state_nxt = S_BUSY;
            S_BUSY: if (xfer_done || xfer_err) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        req_done  = '0;
        req_err   = '0;
        rsp_rdata = avm_readdata;
        if (state == S_BUSY) begin
            grant = onehot2(owner);
            if (xfer_done) req_done = onehot2(owner);
            if (xfer_err)  req_err  = onehot2(owner);
        end
    end

endmodule

// File: tb/tb_avm_uart_arbiter.sv
module tb_avm_uart_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TMO = 16;

    logic            avm_clk = 1'b0;
    logic            avm_rst;
    logic [1:0]      req_valid, req_write, req_lock;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_done, req_err, grant;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   avm_address;
    logic            avm_read, avm_write, avm_waitrequest;
    logic [DW-1:0]   avm_readdata, avm_writedata;

    avm_uart_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .avm_clk         (avm_clk),
        .avm_rst         (avm_rst),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_lock        (req_lock),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_done        (req_done),
        .req_err         (req_err),
        .rsp_rdata       (rsp_rdata),
        .grant           (grant),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 avm_clk = ~avm_clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- slave: waitrequest high for the first wait_cycles busy cycles
    int wait_cycles = 0;
    int slv_cnt = 0;
    always @(posedge avm_clk) begin
        #2;
        if (avm_read || avm_write) begin
            avm_waitrequest = (slv_cnt < wait_cycles);
            slv_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
            slv_cnt = 0;
        end
    end

    // ---------------- behavioural model (owner -1 = bus idle, lock -1 = none)
    int cyc = 0;
    int m_owner = -1, m_last = 1, m_lock = -1, m_wait = 0, m_g;
    logic m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit model_on = 0;

    always @(posedge avm_clk) begin
        cyc++;
        if (avm_rst) begin
            model_on = 1;
            m_owner = -1; m_last = 1; m_lock = -1; m_wait = 0;
        end else if (m_owner < 0) begin
            m_g = -1;
            if (m_lock >= 0 && req_valid[m_lock]) m_g = m_lock;
            else begin
                m_lock = -1;
                if (req_valid == 2'b11) m_g = 1 - m_last;
                else if (req_valid[0]) m_g = 0;
                else if (req_valid[1]) m_g = 1;
            end
            if (m_g >= 0) begin
                m_owner = m_g; m_wait = 0;
                m_wr    = req_write[m_g];
                m_addr  = req_addr[m_g*AW +: AW];
                m_wdata = req_wdata[m_g*DW +: DW];
            end
        end else if (!avm_waitrequest) begin
            m_last = m_owner;
            m_lock = req_lock[m_owner] ? m_owner : -1;
            m_owner = -1;
        end else if (m_wait == TMO - 1) begin
            m_last = m_owner; m_lock = -1; m_owner = -1;
        end else begin
            m_wait++;
        end
    end

    // ---------------- compare + event recording
    typedef struct { int cyc; logic [1:0] g; logic w; logic [DW-1:0] wd; logic [AW-1:0] a; } iss_t;
    typedef struct { int cyc; logic [1:0] d; logic [1:0] e; logic [DW-1:0] rd; } ev_t;
    iss_t iss_q[$];
    ev_t  ev_q[$];
    int   read_hi = 0;
    bit   prev_busy = 0;
    logic [1:0] e_grant, e_done, e_err;

    always @(negedge avm_clk) begin
        if (model_on) begin
            e_grant = 2'b00; e_done = 2'b00; e_err = 2'b00;
            if (m_owner >= 0) begin
                e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
                if (!avm_rst && !avm_waitrequest) e_done = e_grant;
                if (!avm_rst && avm_waitrequest && m_wait == TMO - 1) e_err = e_grant;
                check("avm_read",      avm_read, !m_wr);
                check("avm_write",     avm_write, m_wr);
                check("avm_address",   avm_address, m_addr);
                check("avm_writedata", avm_writedata, m_wdata);
            end else begin
                check("idle_read",  avm_read, 1'b0);
                check("idle_write", avm_write, 1'b0);
            end
            check("grant",    grant, e_grant);
            check("req_done", req_done, e_done);
            check("req_err",  req_err, e_err);
            if (e_done != 2'b00) check("rsp_rdata", rsp_rdata, avm_readdata);
        end
        if (avm_read) read_hi++;
        if ((avm_read || avm_write) && !prev_busy)
            iss_q.push_back('{cyc, grant, avm_write, avm_writedata, avm_address});
        prev_busy = avm_read || avm_write;
        if (req_done != 2'b00 || req_err != 2'b00)
            ev_q.push_back('{cyc, req_done, req_err, rsp_rdata});
    end

    // ---------------- stimulus helpers
    task automatic do_reset();
        avm_rst = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
        req_addr = '0; req_wdata = '0;
        @(posedge avm_clk); #1;
        @(posedge avm_clk); #1;
        avm_rst = 1'b0;
        iss_q.delete(); ev_q.delete(); read_hi = 0;
    endtask

    task automatic wait_done(output logic [1:0] d, output logic [1:0] e);
        bit seen = 0;
        d = 2'b00; e = 2'b00;
        for (int n = 0; n < 100; n++) begin
            @(negedge avm_clk);
            if (req_done != 2'b00 || req_err != 2'b00) begin
                d = req_done; e = req_err; seen = 1;
                break;
            end
        end
        check("wait_bound", seen, 1'b1);
        @(posedge avm_clk); #1;
    endtask

    logic [1:0] d, e;
    logic [1:0] exp_g [4];
    logic [DW-1:0] exp_wd [4];

    initial begin
        avm_rst = 1'b1; avm_readdata = '0; avm_waitrequest = 1'b0;
        req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
        req_addr = '0; req_wdata = '0;

        // T1 single read, 3 wait cycles
        do_reset();
        check("rst_grant", grant, 2'b00);
        check("rst_read", avm_read, 1'b0);
        check("rst_write", avm_write, 1'b0);
        check("rst_addr", avm_address, 0);
        check("rst_wdata", avm_writedata, 0);
        check("rst_done", req_done, 2'b00);
        check("rst_err", req_err, 2'b00);
        wait_cycles = 3; avm_readdata = 32'h80;
        req_valid = 2'b01; req_addr = {5'd0, 5'd8};
        wait_done(d, e);
        req_valid = 2'b00;
        check("t1_done", d, 2'b01);
        check("t1_err", e, 2'b00);
        check("t1_read_cycles", read_hi, 4);
        check("t1_n_issue", iss_q.size(), 1);
        check("t1_n_event", ev_q.size(), 1);
        if (iss_q.size() > 0 && ev_q.size() > 0) begin
            check("t1_addr", iss_q[0].a, 8);
            check("t1_rdata", ev_q[0].rd, 32'h80);
            check("t1_latency", ev_q[0].cyc - iss_q[0].cyc, 3);
        end
        repeat (3) begin @(posedge avm_clk); #1; end
        check("t1_no_reissue", iss_q.size(), 1);

        // T2 contention, zero wait
        do_reset();
        wait_cycles = 0; avm_readdata = 32'h0;
        req_valid = 2'b11; req_write = 2'b10;
        req_addr = {5'd4, 5'd8}; req_wdata = {32'h41, 32'h0};
        for (int k = 0; k < 4; k++) wait_done(d, e);
        req_valid = 2'b00;
        repeat (2) begin @(posedge avm_clk); #1; end
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_wd = '{32'h0, 32'h41, 32'h0, 32'h41};
        check("t2_n_issue", iss_q.size(), 4);
        for (int k = 0; k < 4 && k < iss_q.size(); k++) begin
            check("t2_grant", iss_q[k].g, exp_g[k]);
            check("t2_wdata", iss_q[k].wd, exp_wd[k]);
            if (k > 0) check("t2_spacing", iss_q[k].cyc - iss_q[k-1].cyc, 2);
        end

        // T3 lock held by req0 for three transfers
        do_reset();
        wait_cycles = 0;
        req_valid = 2'b11; req_write = 2'b10; req_lock = 2'b01;
        req_addr = {5'd4, 5'd0}; req_wdata = {32'h41, 32'h0};
        wait_done(d, e);
        wait_done(d, e);
        req_lock = 2'b00;
        wait_done(d, e);
        req_valid = 2'b10;
        wait_done(d, e);
        req_valid = 2'b00;
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b10};
        check("t3_n_issue", iss_q.size(), 4);
        for (int k = 0; k < 4 && k < iss_q.size(); k++)
            check("t3_grant", iss_q[k].g, exp_g[k]);

        // T4 timeout with waitrequest stuck
        do_reset();
        wait_cycles = 1000;
        req_valid = 2'b11; req_write = 2'b00; req_addr = {5'd0, 5'd8};
        wait_done(d, e);
        check("t4_err", e, 2'b01);
        check("t4_done", d, 2'b00);
        check("t4_read_cycles", read_hi, 16);
        check("t4_read_dropped", avm_read, 1'b0);
        if (iss_q.size() > 0 && ev_q.size() > 0)
            check("t4_err_latency", ev_q[0].cyc - iss_q[0].cyc, 15);
        wait_cycles = 0; req_valid = 2'b10;
        wait_done(d, e);
        req_valid = 2'b00;
        check("t4_next_done", d, 2'b10);

        // T5 waitrequest falls in the expiry cycle
        do_reset();
        wait_cycles = 15; avm_readdata = 32'h1234;
        req_valid = 2'b01; req_addr = {5'd0, 5'd8};
        wait_done(d, e);
        req_valid = 2'b00;
        check("t5_done", d, 2'b01);
        check("t5_err", e, 2'b00);
        if (iss_q.size() > 0 && ev_q.size() > 0) begin
            check("t5_rdata", ev_q[0].rd, 32'h1234);
            check("t5_latency", ev_q[0].cyc - iss_q[0].cyc, 15);
        end

        // T6 reset in the middle of a transfer
        do_reset();
        wait_cycles = 1000;
        req_valid = 2'b10; req_write = 2'b00; req_addr = {5'd4, 5'd8};
        repeat (4) begin @(posedge avm_clk); #1; end
        req_valid = 2'b11;
        @(posedge avm_clk); #1;
        check("t6_busy", avm_read, 1'b1);
        avm_rst = 1'b1;
        @(posedge avm_clk); #1;
        check("t6_read_after_rst", avm_read, 1'b0);
        check("t6_grant_after_rst", grant, 2'b00);
        avm_rst = 1'b0;
        check("t6_no_pulse", ev_q.size(), 0);
        wait_cycles = 0;
        wait_done(d, e);
        check("t6_first_done", d, 2'b01);
        wait_done(d, e);
        req_valid = 2'b00;
        check("t6_second_done", d, 2'b10);

        repeat (3) @(posedge avm_clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
